// File: rtl/barrido_teclado.sv
// barrido_teclado: scans a 4x4 active-low keypad one column at a time.
// The rows pass through a 2-flop synchroniser. A press and a release are
// each debounced, and an accepted press issues a one-cycle strobe with the
// code {row, column}.
// Optional feature macro: TECLADO_REPETICION_EN (auto-repeat while held).
module barrido_teclado #(
    parameter int unsigned CICLOS_COLUMNA     = 1000,
    parameter int unsigned CICLOS_ANTIRREBOTE = 20,
    parameter int unsigned CICLOS_REPETICION  = 250000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] filas,
    output logic [3:0] columnas,
    output logic [3:0] codigo_tecla,
    output logic       tecla_valida,
    output logic       tecla_presionada
);

    typedef enum logic [1:0] {BARRIDO, CONFIRMAR, PULSADA, LIBERAR} estado_t;

    localparam int unsigned MAX_CA = (CICLOS_COLUMNA > CICLOS_ANTIRREBOTE) ?
                                     CICLOS_COLUMNA : CICLOS_ANTIRREBOTE;
    localparam int unsigned MAX_P  = (MAX_CA > CICLOS_REPETICION) ? MAX_CA : CICLOS_REPETICION;
    localparam int unsigned CW     = $clog2(MAX_P) + 1;
    localparam logic [CW-1:0] FIN_COLUMNA     = CW'(CICLOS_COLUMNA - 1);
    localparam logic [CW-1:0] FIN_ANTIRREBOTE = CW'(CICLOS_ANTIRREBOTE - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    fila_q, fila_d;
    logic [3:0]    sinc_q, filas_s_q;
    logic [3:0]    codigo_q, codigo_d;
    logic          valida_q, valida_d;
    logic          presionada_q, presionada_d;
    logic          fila_baja;
    logic          rep_pulso;

    // Lowest-index low row wins when several rows are low together.
    function automatic logic [1:0] fila_min(input logic [3:0] f);
        if (!f[0]) return 2'd0;
        if (!f[1]) return 2'd1;
        if (!f[2]) return 2'd2;
        return 2'd3;
    endfunction

    assign fila_baja = ~filas_s_q[fila_q];

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc_q    <= 4'hF;
            filas_s_q <= 4'hF;
        end else begin
            sinc_q    <= filas;
            filas_s_q <= sinc_q;
        end
    end

`ifdef TECLADO_REPETICION_EN
    // A period of 1 would strobe on consecutive cycles, so 2 is the floor.
    localparam int unsigned PERIODO_REP = (CICLOS_REPETICION < 2) ? 2 : CICLOS_REPETICION;
    localparam int unsigned RW          = $clog2(PERIODO_REP) + 1;
    localparam logic [RW-1:0] FIN_REP   = RW'(PERIODO_REP - 1);

    logic [RW-1:0] rep_q, rep_d;

    // Repeat timer: runs only while the key stays held in PULSADA, else cleared.
    always_comb begin
        rep_pulso = 1'b0;
        rep_d     = '0;
        if (estado_q == PULSADA && fila_baja) begin
            if (rep_q == FIN_REP) rep_pulso = 1'b1;
            else                  rep_d     = rep_q + 1'b1;
        end
    end

    // Repeat timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_q <= '0;
        else        rep_q <= rep_d;
    end
`else
    assign rep_pulso = 1'b0;
`endif

    // Scan / debounce FSM: next state, counters and output registers.
    always_comb begin
        estado_d     = estado_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        fila_d       = fila_q;
        codigo_d     = codigo_q;
        valida_d     = 1'b0;
        presionada_d = presionada_q;
        if (valida_q) presionada_d = 1'b1;
        case (estado_q)
            BARRIDO: begin
                if (cnt_q == FIN_COLUMNA) begin
                    cnt_d = '0;
                    if (filas_s_q != 4'hF) begin
                        fila_d   = fila_min(filas_s_q);
                        estado_d = CONFIRMAR;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONFIRMAR: begin
                if (!fila_baja) begin
                    cnt_d    = '0;
                    estado_d = BARRIDO;
                end else if (cnt_q == FIN_ANTIRREBOTE) begin
                    cnt_d    = '0;
                    codigo_d = {fila_q, col_q};
                    valida_d = 1'b1;
                    estado_d = PULSADA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSADA: begin
                if (!fila_baja) begin
                    cnt_d    = '0;
                    estado_d = LIBERAR;
                end else if (rep_pulso) begin
                    valida_d = 1'b1;
                end
            end
            LIBERAR: begin
                if (fila_baja) begin
                    cnt_d    = '0;
                    estado_d = PULSADA;
                end else if (cnt_q == FIN_ANTIRREBOTE) begin
                    cnt_d        = '0;
                    presionada_d = 1'b0;
                    col_d        = col_q + 2'd1;
                    estado_d     = BARRIDO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= BARRIDO;
            cnt_q        <= '0;
            col_q        <= 2'd0;
            fila_q       <= 2'd0;
            codigo_q     <= 4'd0;
            valida_q     <= 1'b0;
            presionada_q <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            fila_q       <= fila_d;
            codigo_q     <= codigo_d;
            valida_q     <= valida_d;
            presionada_q <= presionada_d;
        end
    end

    assign columnas         = ~(4'b0001 << col_q);
    assign codigo_tecla     = codigo_q;
    assign tecla_valida     = valida_q;
    assign tecla_presionada = presionada_q;

endmodule

// File: tb/tb_barrido_teclado.sv
// Testbench for barrido_teclado with CICLOS_COLUMNA=4, CICLOS_ANTIRREBOTE=8,
// CICLOS_REPETICION=32. A keypad model pulls a row low while a pressed key's
// column is driven. Sample s = s-th sampling point after reset release.
module tb_barrido_teclado;

    localparam int CC = 4;
    localparam int CA = 8;
    localparam int CR = 32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  filas;
    logic [3:0]  columnas;
    logic [3:0]  codigo_tecla;
    logic        tecla_valida;
    logic        tecla_presionada;
    logic [15:0] teclas = '0;      // bit 4*row+col set = key held

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int         st_cyc[$];
    logic [3:0] st_cod[$];
    int   consecutivos = 0;
    logic valida_prev  = 1'b0;

    barrido_teclado #(
        .CICLOS_COLUMNA    (CC),
        .CICLOS_ANTIRREBOTE(CA),
        .CICLOS_REPETICION (CR)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .filas           (filas),
        .columnas        (columnas),
        .codigo_tecla    (codigo_tecla),
        .tecla_valida    (tecla_valida),
        .tecla_presionada(tecla_presionada)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a held key shorts its row to its driven (low) column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            filas[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (teclas[4*r+c] && !columnas[c]) filas[r] = 1'b0;
        end
    end

    // Strobe recorder, times relative to the last reset release.
    always @(negedge clk) begin
        if (rst_n && tecla_valida) begin
            st_cyc.push_back(cyc - t0);
            st_cod.push_back(codigo_tecla);
            if (valida_prev) consecutivos++;
        end
        valida_prev = tecla_valida;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Strobes expected for a press accepted at a and released at rel: the
    // initial one, plus with auto-repeat one every CR cycles while the
    // synchronised row (2 cycles late) is still low on the cycle before.
    function automatic int n_strobes(input int a, input int rel);
        int n;
        n = (rel < a) ? 0 : 1;
`ifdef TECLADO_REPETICION_EN
        while (n > 0 && a + CR * n <= rel + 2) n++;
`endif
        return n;
    endfunction

    task automatic ciclo();
        @(negedge clk);
        #1;
    endtask

    task automatic hasta(input int s);
        while (cyc - t0 < s) ciclo();
    endtask

    task automatic aplicar_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        t0 = cyc;
        st_cyc.delete();
        st_cod.delete();
    endtask

    task automatic test_reset();
        teclas = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (columnas !== 4'b1110) begin failures++; $display("FAIL reset_columnas got=%b exp=1110", columnas); end
        checks++; if (codigo_tecla !== 4'd0) begin failures++; $display("FAIL reset_codigo got=%b exp=0000", codigo_tecla); end
        checks++; if (tecla_valida !== 1'b0) begin failures++; $display("FAIL reset_valida got=%b exp=0", tecla_valida); end
        checks++; if (tecla_presionada !== 1'b0) begin failures++; $display("FAIL reset_presionada got=%b exp=0", tecla_presionada); end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        t0 = cyc;
        st_cyc.delete();
        st_cod.delete();
    endtask

    task automatic test_barrido_libre();
        logic [3:0] exp;
        for (int s = 0; s < 40; s++) begin
            hasta(s);
            exp = ~(4'b0001 << ((s / CC) % 4));
            checks++; if (columnas !== exp) begin failures++; $display("FAIL idle_columnas s=%0d got=%b exp=%b", s, columnas, exp); end
        end
        checks++; if (st_cyc.size() != 0) begin failures++; $display("FAIL idle_strobes got=%0d exp=0", st_cyc.size()); end
    endtask

    task automatic test_pulsacion();
        int ne;
        logic exp_p;
        aplicar_reset();
        teclas[6] = 1'b1;                       // row 1, column 2
        for (int s = 1; s <= 100; s++) begin
            hasta(s);
            exp_p = (s >= 21 && s <= 90);
            checks++; if (tecla_presionada !== exp_p) begin failures++; $display("FAIL press_presionada s=%0d got=%b exp=%b", s, tecla_presionada, exp_p); end
            if (s == 50 || s == 90) begin
                checks++; if (columnas !== 4'b1011) begin failures++; $display("FAIL press_col_held s=%0d got=%b exp=1011", s, columnas); end
            end
            if (s == 91 || s == 94) begin
                checks++; if (columnas !== 4'b0111) begin failures++; $display("FAIL press_col_next s=%0d got=%b exp=0111", s, columnas); end
            end
            if (s == 95) begin
                checks++; if (columnas !== 4'b1110) begin failures++; $display("FAIL press_col_wrap got=%b exp=1110", columnas); end
            end
            if (s == 80) teclas = '0;
        end
        ne = n_strobes(20, 80);
        checks++;
        if (st_cyc.size() != ne) begin
            failures++; $display("FAIL press_nstrobes got=%0d exp=%0d", st_cyc.size(), ne);
        end else begin
            for (int m = 0; m < ne; m++) begin
                checks++;
                if (st_cyc[m] != 20 + CR * m || st_cod[m] !== 4'b0110) begin
                    failures++; $display("FAIL press_strobe m=%0d got=@%0d/%b exp=@%0d/0110", m, st_cyc[m], st_cod[m], 20 + CR * m);
                end
            end
        end
    endtask

    task automatic test_rebote();
        aplicar_reset();
        teclas[0] = 1'b1;                       // row 0, column 0, bouncing
        for (int s = 1; s <= 40; s++) begin
            hasta(s);
            if (s == 3) teclas = '0;
            if (s == 9) begin
                checks++; if (columnas !== 4'b1110) begin failures++; $display("FAIL bounce_col_restart got=%b exp=1110", columnas); end
            end
            if (s == 10) begin
                checks++; if (columnas !== 4'b1101) begin failures++; $display("FAIL bounce_col_next got=%b exp=1101", columnas); end
            end
        end
        checks++; if (st_cyc.size() != 0) begin failures++; $display("FAIL bounce_strobes got=%0d exp=0", st_cyc.size()); end
        checks++; if (codigo_tecla !== 4'd0) begin failures++; $display("FAIL bounce_codigo got=%b exp=0000", codigo_tecla); end
        checks++; if (tecla_presionada !== 1'b0) begin failures++; $display("FAIL bounce_presionada got=%b exp=0", tecla_presionada); end
    endtask

    task automatic test_simultaneas();
        bit ok;
        int a, rr;
        aplicar_reset();
        teclas[1] = 1'b1;                       // row 0, column 1
        teclas[9] = 1'b1;                       // row 2, column 1
        for (int s = 1; s <= 75; s++) begin
            hasta(s);
            if (s == 60) teclas = '0;
        end
        checks++;
        if (st_cyc.size() != 1 || st_cyc[0] != 16 || st_cod[0] !== 4'b0001) begin
            failures++; $display("FAIL multi_strobe got n=%0d exp n=1 @16 code 0001", st_cyc.size());
        end
        hasta(80);
        st_cyc.delete(); st_cod.delete();
        teclas[15] = 1'b1;                      // row 3, column 3
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            ciclo();
            if (st_cyc.size() > 0) ok = 1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL glitch_accept_timeout got=no strobe exp=strobe"); end
        if (ok) begin
            a  = st_cyc[0];
            rr = a + 20;
            checks++; if (a < 91 || a > 107) begin failures++; $display("FAIL glitch_accept_time got=%0d exp=91..107", a); end
            hasta(rr);     teclas = '0;
            hasta(rr + 4); teclas[15] = 1'b1;   // glitch lands inside the release debounce
            hasta(rr + 8); teclas = '0;
            hasta(rr + 11);
            checks++; if (tecla_presionada !== 1'b1) begin failures++; $display("FAIL glitch_held_a got=%b exp=1", tecla_presionada); end
            hasta(rr + 18);
            checks++; if (tecla_presionada !== 1'b1) begin failures++; $display("FAIL glitch_held_b got=%b exp=1", tecla_presionada); end
            hasta(rr + 19);
            checks++; if (tecla_presionada !== 1'b0) begin failures++; $display("FAIL glitch_release got=%b exp=0", tecla_presionada); end
            hasta(rr + 30);
            checks++; if (st_cyc.size() != 1) begin failures++; $display("FAIL glitch_nstrobes got=%0d exp=1", st_cyc.size()); end
            checks++; if (st_cod[0] !== 4'b1111 || codigo_tecla !== 4'b1111) begin failures++; $display("FAIL glitch_codigo got=%b exp=1111", codigo_tecla); end
        end
    endtask

    task automatic test_reset_confirmar();
        aplicar_reset();
        teclas[6] = 1'b1;                       // accept 0110 first
        hasta(40); teclas = '0;
        hasta(45); teclas[3] = 1'b1;            // row 0, column 3: confirming 55..62
        hasta(57);
        checks++; if (columnas !== 4'b0111) begin failures++; $display("FAIL rstc_in_confirm got=%b exp=0111", columnas); end
        checks++; if (codigo_tecla !== 4'b0110) begin failures++; $display("FAIL rstc_prev_code got=%b exp=0110", codigo_tecla); end
        hasta(58);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (columnas !== 4'b1110) begin failures++; $display("FAIL rstc_columnas got=%b exp=1110", columnas); end
        checks++; if (codigo_tecla !== 4'd0) begin failures++; $display("FAIL rstc_codigo got=%b exp=0000", codigo_tecla); end
        checks++; if (tecla_valida !== 1'b0 || tecla_presionada !== 1'b0) begin failures++; $display("FAIL rstc_flags got=%b%b exp=00", tecla_valida, tecla_presionada); end
        teclas = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        t0 = cyc;
        st_cyc.delete(); st_cod.delete();
        hasta(40);
        checks++; if (st_cyc.size() != 0) begin failures++; $display("FAIL rstc_strobes got=%0d exp=0", st_cyc.size()); end
    endtask

    task automatic test_repeticion();
        bit ok;
        int a, ne;
        aplicar_reset();
        teclas[8] = 1'b1;                       // row 2, column 0
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ciclo();
            if (st_cyc.size() > 0) ok = 1;
        end
        checks++; if (!ok) begin failures++; $display("FAIL rep_accept_timeout got=no strobe exp=strobe"); end
        if (ok) begin
            a = st_cyc[0];
            checks++; if (a != 12) begin failures++; $display("FAIL rep_accept_time got=%0d exp=12", a); end
            hasta(a + 110); teclas = '0;
            hasta(a + 140);
            ne = n_strobes(a, a + 110);
            checks++;
            if (st_cyc.size() != ne) begin
                failures++; $display("FAIL rep_nstrobes got=%0d exp=%0d", st_cyc.size(), ne);
            end else begin
                for (int m = 0; m < ne; m++) begin
                    checks++;
                    if (st_cyc[m] != a + CR * m || st_cod[m] !== 4'b1000) begin
                        failures++; $display("FAIL rep_strobe m=%0d got=@%0d/%b exp=@%0d/1000", m, st_cyc[m], st_cod[m], a + CR * m);
                    end
                end
            end
        end
    endtask

    task automatic test_aleatorio();
        int c, hold, gap, p, rel, a, ne, fila;
        logic [3:0] mask, exp_cod;
        aplicar_reset();
        for (int n = 0; n < 12; n++) begin
            c    = $urandom_range(3, 0);
            mask = 4'($urandom_range(15, 1));
            hold = $urandom_range(100, 40);
            gap  = $urandom_range(20, 5);
            repeat (gap) ciclo();
            st_cyc.delete(); st_cod.delete();
            p    = cyc - t0;
            fila = 3;
            for (int r = 3; r >= 0; r--)
                if (mask[r]) begin teclas[4*r+c] = 1'b1; fila = r; end
            exp_cod = 4'(4 * fila + c);
            repeat (hold) ciclo();
            rel = cyc - t0;
            teclas = '0;
            repeat (10) ciclo();
            checks++; if (tecla_presionada !== 1'b1) begin failures++; $display("FAIL rand_held n=%0d got=%b exp=1", n, tecla_presionada); end
            ciclo();
            checks++; if (tecla_presionada !== 1'b0) begin failures++; $display("FAIL rand_release n=%0d got=%b exp=0", n, tecla_presionada); end
            repeat (4) ciclo();
            checks++;
            if (st_cyc.size() == 0) begin
                failures++; $display("FAIL rand_nostrobe n=%0d got=0 exp>=1", n);
            end else begin
                a  = st_cyc[0];
                ne = n_strobes(a, rel);
                checks++; if (a < p + 11 || a > p + 27) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d..%0d", n, a - p, 11, 27); end
                checks++; if (st_cyc.size() != ne) begin failures++; $display("FAIL rand_nstrobes n=%0d got=%0d exp=%0d", n, st_cyc.size(), ne); end
                for (int m = 0; m < st_cyc.size(); m++) begin
                    checks++;
                    if (st_cod[m] !== exp_cod || st_cyc[m] != a + CR * m) begin
                        failures++; $display("FAIL rand_strobe n=%0d m=%0d got=@%0d/%b exp=@%0d/%b", n, m, st_cyc[m], st_cod[m], a + CR * m, exp_cod);
                    end
                end
            end
        end
    endtask

    task automatic test_sin_consecutivos();
        checks++; if (consecutivos != 0) begin failures++; $display("FAIL back_to_back_strobes got=%0d exp=0", consecutivos); end
    endtask

    initial begin
        test_reset();
        test_barrido_libre();
        test_pulsacion();
        test_rebote();
        test_simultaneas();
        test_reset_confirmar();
        test_repeticion();
        test_aleatorio();
        test_sin_consecutivos();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
